fifo_wr_arbiter: RTL and testbench



---
 rtl/fifo_wr_arbiter_pkg.sv | 28 ++
 rtl/fifo_wr_arbiter_rr_pick.sv | 32 +++
 rtl/fifo_wr_arbiter.sv | 146 ++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared definitions for the FIFO write-side arbiter.
//   state_e   : FSM encoding (IDLE / XFER)
//   clog2     : ceiling log2, clamped to a minimum width of 1
//   slice_lsb : LSB of source idx inside a packed {src N-1, ..., src 0} data bus
package fifo_wr_arbiter_pkg;

    typedef enum logic {
        StIdle = 1'b0,
        StXfer = 1'b1
    } state_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return (result == 0) ? 1 : result;
    endfunction

    // Source i occupies bits [i*dw +: dw] of the concatenated data bus.
    function automatic int unsigned slice_lsb(input int unsigned idx, input int unsigned dw);
        return idx * dw;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin selector.
//   req : per-source request vector
//   ptr : index the search starts from (wraps modulo N_SRC)
//   any : at least one request is set
//   idx : first requesting index at or after ptr
module rr_pick #(
    parameter int unsigned N_SRC = 4,
    parameter int unsigned IdW   = 2
) (
    input  logic [N_SRC-1:0] req,
    input  logic [IdW-1:0]   ptr,
    output logic             any,
    output logic [IdW-1:0]   idx
);

    int unsigned cand;

    always_comb begin
        any  = 1'b0;
        idx  = '0;
        cand = 0;
        for (int unsigned off = 0; off < N_SRC; off++) begin
            cand = (32'(ptr) + off) % N_SRC;
            // Only the first hit in search order counts.
            if (!any && req[IdW'(cand)]) begin
                any = 1'b1;
                idx = IdW'(cand);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Write-side scheduler sharing one FIFO write port among N_SRC packet sources.
// Round-robin at packet/burst granularity, honours fifo_full, one bubble between grants.
//   clk_wr, rst            : write clock, asynchronous active-low reset
//   src_valid/data/last    : per-source beat stream (source i at data[i*DW +: DW])
//   src_ready              : beat accepted when ANDed with src_valid
//   fifo_we, fifo_wdata    : FIFO write port
//   fifo_full              : FIFO full flag (clk_wr domain)
//   grant_vld, grant_id    : current grant holder
//   timeout_pulse          : one cycle after a grant is revoked for idling
module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int unsigned N_SRC     = 4,
    parameter int unsigned DW        = 8,
    parameter int unsigned MAX_BURST = 8,
    parameter int unsigned IDLE_TO   = 16
) (
    input  logic                    clk_wr,
    input  logic                    rst,
    input  logic [N_SRC-1:0]        src_valid,
    input  logic [N_SRC*DW-1:0]     src_data,
    input  logic [N_SRC-1:0]        src_last,
    output logic [N_SRC-1:0]        src_ready,
    output logic                    fifo_we,
    output logic [DW-1:0]           fifo_wdata,
    input  logic                    fifo_full,
    output logic                    grant_vld,
    output logic [clog2(N_SRC)-1:0] grant_id,
    output logic                    timeout_pulse
);

    localparam int unsigned IdW = clog2(N_SRC);
    localparam int unsigned BcW = clog2(MAX_BURST + 1);
    localparam int unsigned IcW = clog2(IDLE_TO + 1);

    localparam logic [BcW-1:0] BurstLast = BcW'(MAX_BURST - 1);
    localparam logic [IcW-1:0] IdleLast  = IcW'(IDLE_TO - 1);
    localparam logic [IdW-1:0] LastSrc   = IdW'(N_SRC - 1);

    state_e         state_q, state_d;
    logic [IdW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IdW-1:0] grant_id_q, grant_id_d;
    logic [BcW-1:0] beat_cnt_q, beat_cnt_d;
    logic [IcW-1:0] idle_cnt_q, idle_cnt_d;
    logic           timeout_q, timeout_d;

    logic           pick_any;
    logic [IdW-1:0] pick_idx;
    logic           g_valid;
    logic           g_last;
    logic           accept;
    logic           rel;

    rr_pick #(
        .N_SRC (N_SRC),
        .IdW   (IdW)
    ) u_rr_pick (
        .req (src_valid),
        .ptr (rr_ptr_q),
        .any (pick_any),
        .idx (pick_idx)
    );

    // Datapath and handshake outputs.
    always_comb begin
        grant_vld     = (state_q == StXfer);
        grant_id      = grant_id_q;
        timeout_pulse = timeout_q;
        g_valid       = src_valid[grant_id_q];
        g_last        = src_last[grant_id_q];
        accept        = grant_vld && g_valid && !fifo_full;
        fifo_we       = accept;
        fifo_wdata    = '0;
        src_ready     = '0;
        if (grant_vld) begin
            fifo_wdata            = src_data[slice_lsb(32'(grant_id_q), DW) +: DW];
            src_ready[grant_id_q] = !fifo_full;
        end
    end

    // Next-state: grant selection, burst/idle accounting, release.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_id_d = grant_id_q;
        beat_cnt_d = beat_cnt_q;
        idle_cnt_d = idle_cnt_q;
        timeout_d  = 1'b0;
        rel        = 1'b0;
        case (state_q)
            StIdle: begin
                if (pick_any) begin
                    state_d    = StXfer;
                    grant_id_d = pick_idx;
                    beat_cnt_d = '0;
                    idle_cnt_d = '0;
                end
            end
            StXfer: begin
                if (accept) begin
                    if (beat_cnt_q != '1) begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                    idle_cnt_d = '0;
                    // last and burst limit on the same beat give a single release.
                    if (g_last || (beat_cnt_q == BurstLast)) begin
                        rel = 1'b1;
                    end
                end else if (!g_valid) begin
                    if (idle_cnt_q != '1) begin
                        idle_cnt_d = idle_cnt_q + 1'b1;
                    end
                    if (idle_cnt_q >= IdleLast) begin
                        rel       = 1'b1;
                        timeout_d = 1'b1;
                    end
                end
                // Valid but full is backpressure: counters hold, grant is kept.
                if (rel) begin
                    state_d  = StIdle;
                    rr_ptr_d = (grant_id_q == LastSrc) ? '0 : grant_id_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_wr or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            rr_ptr_q   <= '0;
            grant_id_q <= '0;
            beat_cnt_q <= '0;
            idle_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_id_q <= grant_id_d;
            beat_cnt_q <= beat_cnt_d;
            idle_cnt_q <= idle_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: directed packets are loaded into per-source
// queues, expected writes are queued by hand, and a negedge monitor checks every write.
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;

    logic            clk_wr = 1'b0;
    logic            rst = 1'b0;
    logic [N-1:0]    src_valid = '0;
    logic [N*DW-1:0] src_data = '0;
    logic [N-1:0]    src_last = '0;
    logic [N-1:0]    src_ready;
    logic            fifo_we;
    logic [DW-1:0]   fifo_wdata;
    logic            fifo_full = 1'b0;
    logic            grant_vld;
    logic [1:0]      grant_id;
    logic            timeout_pulse;

    fifo_wr_arbiter #(
        .N_SRC     (N),
        .DW        (DW),
        .MAX_BURST (8),
        .IDLE_TO   (16)
    ) dut (
        .clk_wr        (clk_wr),
        .rst           (rst),
        .src_valid     (src_valid),
        .src_data      (src_data),
        .src_last      (src_last),
        .src_ready     (src_ready),
        .fifo_we       (fifo_we),
        .fifo_wdata    (fifo_wdata),
        .fifo_full     (fifo_full),
        .grant_vld     (grant_vld),
        .grant_id      (grant_id),
        .timeout_pulse (timeout_pulse)
    );

    always #5 clk_wr = ~clk_wr;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] d;
    } exp_t;

    exp_t       exp_q[$];
    logic [8:0] sq[N][$];   // {last, data} per source
    int         n_chk = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         wr_cnt = 0;
    int         cur_beats = 0;
    int         g_ids[$];
    int         g_start[$];
    int         g_beats[$];
    int         to_cycles[$];
    logic       gv_prev = 1'b0;
    logic [N-1:0] acc;

    task automatic check(input string name, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, req, req);
        end
    endtask

    function automatic int at(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    task automatic load(input int src, input int n, input int base, input bit last_at_end);
        logic lb;
        for (int k = 0; k < n; k++) begin
            lb = last_at_end && (k == n - 1);
            sq[src].push_back({lb, 8'(base + k)});
        end
    endtask

    task automatic expect_run(input int src, input int n, input int base);
        for (int k = 0; k < n; k++) exp_q.push_back({2'(src), 8'(base + k)});
    endtask

    task automatic clear_logs();
        g_ids.delete();
        g_start.delete();
        g_beats.delete();
        to_cycles.delete();
    endtask

    function automatic bit all_idle();
        bit ok;
        ok = (exp_q.size() == 0) && !grant_vld && (src_valid == '0);
        for (int i = 0; i < N; i++) if (sq[i].size() != 0) ok = 0;
        return ok;
    endfunction

    task automatic wait_done(input string name, input int budget);
        int k;
        k = 0;
        do begin
            @(negedge clk_wr);
            #1;
            k++;
        end while (!all_idle() && k < budget);
        check({name, "_done"}, int'(all_idle()), 1);
        repeat (2) @(negedge clk_wr);
    endtask

    task automatic wait_writes(input string name, input int target, input int budget);
        int k;
        k = 0;
        do begin
            @(negedge clk_wr);
            #1;
            k++;
        end while (wr_cnt < target && k < budget);
        check({name, "_writes"}, wr_cnt, target);
    endtask

    // Cycle counter.
    initial forever begin
        @(posedge clk_wr);
        cyc++;
    end

    // Source driver: pops beats accepted at the previous edge, presents the next one.
    initial forever begin
        @(negedge clk_wr);
        acc = src_valid & src_ready;
        @(posedge clk_wr);
        #2;
        for (int i = 0; i < N; i++) begin
            if (acc[i] && sq[i].size() > 0) void'(sq[i].pop_front());
            if (sq[i].size() > 0) begin
                src_valid[i]          = 1'b1;
                src_data[i*DW +: DW]  = sq[i][0][7:0];
                src_last[i]           = sq[i][0][8];
            end else begin
                src_valid[i]          = 1'b0;
                src_data[i*DW +: DW]  = '0;
                src_last[i]           = 1'b0;
            end
        end
    end

    // Monitor / scoreboard.
    initial forever begin
        logic [N-1:0] er;
        exp_t         e;
        @(negedge clk_wr);
        if (grant_vld && !gv_prev) begin
            g_ids.push_back(int'(grant_id));
            g_start.push_back(cyc);
            cur_beats = 0;
        end
        if (fifo_we) begin
            wr_cnt++;
            cur_beats++;
            if (exp_q.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL unexpected_write: src %0d data 0x%0h, expected no write",
                         grant_id, fifo_wdata);
            end else begin
                e = exp_q.pop_front();
                check("wr_src", int'(grant_id), int'(e.id));
                check("wr_data", int'(fifo_wdata), int'(e.d));
            end
        end
        if (!grant_vld && gv_prev) g_beats.push_back(cur_beats);
        if (timeout_pulse) to_cycles.push_back(cyc);
        gv_prev = grant_vld;
        er = '0;
        if (grant_vld) er[grant_id] = !fifo_full;
        check("src_ready", int'(src_ready), int'(er));
        if (!grant_vld) check("wdata_idle", int'(fifo_wdata), 0);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk_wr);
        check("rst_grant_vld", int'(grant_vld), 0);
        check("rst_grant_id", int'(grant_id), 0);
        check("rst_fifo_we", int'(fifo_we), 0);
        check("rst_src_ready", int'(src_ready), 0);
        check("rst_timeout", int'(timeout_pulse), 0);
        @(posedge clk_wr);
        #1 rst = 1'b1;
        repeat (2) @(negedge clk_wr);

        // Test 1: single 3-beat packet on src0, grant latency one cycle
        clear_logs();
        @(posedge clk_wr);
        #1;
        load(0, 3, 'h10, 1);
        expect_run(0, 3, 'h10);
        @(negedge clk_wr);
        check("t1_valid", int'(src_valid[0]), 1);
        check("t1_lat_before", int'(grant_vld), 0);
        @(negedge clk_wr);
        check("t1_lat_grant", int'(grant_vld), 1);
        check("t1_lat_id", int'(grant_id), 0);
        wait_done("t1", 40);
        check("t1_gid", at(g_ids, 0), 0);
        check("t1_beats", at(g_beats, 0), 3);
        check("t1_ngrants", g_ids.size(), 1);
        // rr_ptr now 1: src1 must beat src0
        clear_logs();
        @(posedge clk_wr);
        #1;
        load(0, 1, 'h18, 1);
        load(1, 1, 'h19, 1);
        expect_run(1, 1, 'h19);
        expect_run(0, 1, 'h18);
        wait_done("t1b", 40);
        check("t1b_first", at(g_ids, 0), 1);
        check("t1b_second", at(g_ids, 1), 0);

        // Test 2: all sources saturated, no last, MAX_BURST=8; rr_ptr starts at 1
        clear_logs();
        @(posedge clk_wr);
        #1;
        load(1, 16, 'h20, 0);
        load(2, 8, 'h30, 0);
        load(3, 8, 'h40, 0);
        load(0, 8, 'h50, 0);
        expect_run(1, 8, 'h20);
        expect_run(2, 8, 'h30);
        expect_run(3, 8, 'h40);
        expect_run(0, 8, 'h50);
        expect_run(1, 8, 'h28);
        wait_done("t2", 200);
        check("t2_ngrants", g_ids.size(), 5);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("t2_gid%0d", k), at(g_ids, k), (k + 1) % 4);
            check($sformatf("t2_beats%0d", k), at(g_beats, k), 8);
        end
        for (int k = 0; k < 4; k++) begin
            check($sformatf("t2_gap%0d", k), at(g_start, k + 1) - at(g_start, k), 9);
        end
        check("t2_no_timeout", to_cycles.size(), 0);

        // Test 3: src1 with 5 cycles of fifo_full mid-burst
        clear_logs();
        @(posedge clk_wr);
        #1;
        load(1, 4, 'h60, 1);
        expect_run(1, 4, 'h60);
        wait_writes("t3", wr_cnt + 2, 40);
        @(posedge clk_wr);
        #1 fifo_full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_wr);
            check("t3_we_full", int'(fifo_we), 0);
            check("t3_rdy_full", int'(src_ready), 0);
            check("t3_grant_held", int'(grant_vld), 1);
        end
        @(posedge clk_wr);
        #1 fifo_full = 1'b0;
        wait_done("t3", 40);
        check("t3_ngrants", g_ids.size(), 1);
        check("t3_beats", at(g_beats, 0), 4);
        check("t3_no_timeout", to_cycles.size(), 0);

        // Test 4: src2 sends 2 beats then idles; src3 pending
        clear_logs();
        @(posedge clk_wr);
        #1;
        load(2, 2, 'h70, 0);
        load(3, 1, 'h80, 1);
        expect_run(2, 2, 'h70);
        expect_run(3, 1, 'h80);
        wait_done("t4", 80);
        check("t4_gid0", at(g_ids, 0), 2);
        check("t4_gid1", at(g_ids, 1), 3);
        check("t4_beats0", at(g_beats, 0), 2);
        check("t4_beats1", at(g_beats, 1), 1);
        check("t4_npulse", to_cycles.size(), 1);
        check("t4_pulse_at", at(to_cycles, 0) - at(g_start, 0), 18);
        check("t4_next_grant", at(g_start, 1) - at(g_start, 0), 19);

        // Test 5: move rr_ptr to 3, then src2+src3 request; last coincides with beat 8
        clear_logs();
        @(posedge clk_wr);
        #1;
        load(2, 1, 'h90, 1);
        expect_run(2, 1, 'h90);
        wait_done("t5a", 40);
        clear_logs();
        @(posedge clk_wr);
        #1;
        load(3, 8, 'hb0, 1);
        load(2, 8, 'ha0, 1);
        expect_run(3, 8, 'hb0);
        expect_run(2, 8, 'ha0);
        wait_done("t5", 80);
        check("t5_ngrants", g_ids.size(), 2);
        check("t5_gid0", at(g_ids, 0), 3);
        check("t5_gid1", at(g_ids, 1), 2);
        check("t5_beats0", at(g_beats, 0), 8);
        check("t5_beats1", at(g_beats, 1), 8);
        check("t5_gap", at(g_start, 1) - at(g_start, 0), 9);
        check("t5_no_timeout", to_cycles.size(), 0);

        // Test 6: reset mid-burst with beat 4 held under full
        clear_logs();
        @(posedge clk_wr);
        #1;
        load(1, 6, 'hc0, 1);
        expect_run(1, 3, 'hc0);
        wait_writes("t6", wr_cnt + 3, 40);
        @(posedge clk_wr);
        #1;
        fifo_full = 1'b1;
        load(3, 1, 'hd0, 1);
        @(negedge clk_wr);
        check("t6_pre_grant", int'(grant_vld), 1);
        check("t6_pre_we", int'(fifo_we), 0);
        @(posedge clk_wr);
        #3 rst = 1'b0;
        #1;
        check("t6_rst_grant", int'(grant_vld), 0);
        check("t6_rst_we", int'(fifo_we), 0);
        check("t6_rst_ready", int'(src_ready), 0);
        check("t6_rst_id", int'(grant_id), 0);
        expect_run(1, 3, 'hc3);
        expect_run(3, 1, 'hd0);
        @(posedge clk_wr);
        #1 fifo_full = 1'b0;
        @(posedge clk_wr);
        #3 rst = 1'b1;
        wait_done("t6", 60);
        check("t6_ngrants", g_ids.size(), 3);
        check("t6_gid_after", at(g_ids, 1), 1);
        check("t6_gid_last", at(g_ids, 2), 3);
        check("t6_beats_cut", at(g_beats, 0), 3);
        check("t6_beats_resume", at(g_beats, 1), 3);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
